// File: rtl/mem_ctrl64_pkg.sv
// rtl/mem_ctrl64_pkg.sv - shared widths and FSM state encoding for mem_ctrl64
package mem_ctrl64_pkg;

    localparam int AW_DEF = 6;
    localparam int DW_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WR   = 2'b01,
        ST_RD   = 2'b10,
        ST_CLR  = 2'b11
    } state_e;

endpackage

// File: rtl/mem_sweep_cnt.sv
// rtl/mem_sweep_cnt.sv - address counter for the clear sweep with terminal-count flag
module mem_sweep_cnt #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // next count: sync clear wins over enable; natural wrap after all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = &cnt_q;

endmodule

// File: rtl/mem_ctrl64.sv
// rtl/mem_ctrl64.sv - single-port RAM controller with host read/write and full clear sweep
module mem_ctrl64
    import mem_ctrl64_pkg::*;
#(
    parameter int            AW        = AW_DEF,
    parameter int            DW        = DW_DEF,
    parameter logic [DW-1:0] CLR_VALUE = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    input  logic          clr_start,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          ram_e,
    output logic [AW-1:0] ram_addr,
    output logic          ram_w,
    output logic          ram_r,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic          rsp_valid_q;
    logic          clr_done_q;
    logic [AW-1:0] sweep_addr;
    logic          sweep_tc;
    logic          req_fire;

    // rst gates ready combinationally so nothing is offered while reset is held
    assign req_ready = (state_q == ST_IDLE) && !clr_start && !rst;
    assign req_fire  = req_valid && req_ready;

    mem_sweep_cnt #(
        .W (AW)
    ) u_sweep_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (state_q != ST_CLR),
        .en_i  (state_q == ST_CLR),
        .cnt_o (sweep_addr),
        .tc_o  (sweep_tc)
    );

    // next-state and RAM strobes; every strobe is 0 in IDLE
    always_comb begin
        state_d  = state_q;
        ram_e    = 1'b0;
        ram_w    = 1'b0;
        ram_r    = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        case (state_q)
            ST_IDLE: begin
                if (clr_start) begin
                    state_d = ST_CLR;
                end else if (req_fire) begin
                    state_d = req_we ? ST_WR : ST_RD;
                end
            end
            ST_WR: begin
                ram_e    = 1'b1;
                ram_w    = 1'b1;
                ram_addr = addr_q;
                ram_din  = wdata_q;
                state_d  = ST_IDLE;
            end
            ST_RD: begin
                ram_e    = 1'b1;
                ram_r    = 1'b1;
                ram_addr = addr_q;
                state_d  = ST_IDLE;
            end
            ST_CLR: begin
                ram_e    = 1'b1;
                ram_w    = 1'b1;
                ram_addr = sweep_addr;
                ram_din  = CLR_VALUE;
                if (sweep_tc) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // request capture, read data capture and completion pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            clr_done_q  <= 1'b0;
        end else begin
            if (req_fire) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state_q == ST_RD) begin
                rdata_q <= ram_dout;
            end
            rsp_valid_q <= (state_q == ST_WR) || (state_q == ST_RD);
            clr_done_q  <= (state_q == ST_CLR) && sweep_tc;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign clr_busy  = (state_q == ST_CLR);
    assign clr_done  = clr_done_q;

endmodule

// File: tb/tb_mem_ctrl64.sv
// tb/tb_mem_ctrl64.sv - directed self-checking bench for mem_ctrl64
module tb_mem_ctrl64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [5:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        clr_start = 1'b0;
    logic        clr_busy;
    logic        clr_done;
    logic        ram_e;
    logic [5:0]  ram_addr;
    logic        ram_w;
    logic        ram_r;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;

    logic [15:0] mem [64];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_ctrl64 dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .ram_e     (ram_e),
        .ram_addr  (ram_addr),
        .ram_w     (ram_w),
        .ram_r     (ram_r),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    always @(posedge clk) begin
        if (ram_e && ram_w) mem[ram_addr] <= ram_din;
    end
    assign ram_dout = (ram_e && ram_r) ? mem[ram_addr] : 16'h0000;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [5:0] a, input logic [15:0] d);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        tick;
        req_valid = 1'b0;
        tick;
        tick;
    endtask

    task automatic do_read(input logic [5:0] a, output logic [15:0] d, output logic v);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a;
        tick;
        req_valid = 1'b0;
        tick;
        v = rsp_valid;
        d = rsp_rdata;
        tick;
    endtask

    task automatic test_reset;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd3;
        for (int i = 0; i < 3; i++) begin
            tick;
            n_cmp++;
            if ({req_ready, ram_e, ram_w, ram_r, rsp_valid, clr_busy, clr_done} !== 7'b0 || rsp_rdata !== 16'h0) begin
                n_err++;
                $display("FAIL reset_outputs cyc %0d: ready=%b e=%b w=%b r=%b rv=%b busy=%b done=%b rdata=%h, required all 0",
                         i, req_ready, ram_e, ram_w, ram_r, rsp_valid, clr_busy, clr_done, rsp_rdata);
            end
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_after_reset: got %b required 1", req_ready);
        end
        tick;
        req_valid = 1'b0;
        n_cmp++;
        if (ram_e !== 1'b1 || ram_r !== 1'b1 || ram_w !== 1'b0 || ram_addr !== 6'd3) begin
            n_err++;
            $display("FAIL first_accept: e=%b r=%b w=%b addr=%0d required 1 1 0 3", ram_e, ram_r, ram_w, ram_addr);
        end
        tick;
        tick;
    endtask

    task automatic test_write_read;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 6'd5; req_wdata = 16'hA5A5;
        #1;
        tick;
        req_valid = 1'b0;
        n_cmp++;
        if (ram_e !== 1'b1 || ram_w !== 1'b1 || ram_r !== 1'b0 || ram_addr !== 6'd5 || ram_din !== 16'hA5A5
            || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL wr_strobe: e=%b w=%b r=%b addr=%0d din=%h rv=%b rdy=%b required 1 1 0 5 a5a5 0 0",
                     ram_e, ram_w, ram_r, ram_addr, ram_din, rsp_valid, req_ready);
        end
        tick;
        n_cmp++;
        if (rsp_valid !== 1'b1 || ram_w !== 1'b0 || req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL wr_rsp: rv=%b w=%b rdy=%b required 1 0 1", rsp_valid, ram_w, req_ready);
        end
        req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd5;
        tick;
        req_valid = 1'b0;
        n_cmp++;
        if (ram_r !== 1'b1 || ram_w !== 1'b0 || ram_addr !== 6'd5 || rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rd_strobe: r=%b w=%b addr=%0d rv=%b required 1 0 5 0", ram_r, ram_w, ram_addr, rsp_valid);
        end
        tick;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 16'hA5A5) begin
            n_err++;
            $display("FAIL rd_rsp: rv=%b rdata=%h required 1 a5a5", rsp_valid, rsp_rdata);
        end
        tick;
        do_write(6'd6, 16'h1111);
        n_cmp++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 16'hA5A5) begin
            n_err++;
            $display("FAIL rdata_hold: rv=%b rdata=%h required 0 a5a5", rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_back_to_back;
        int acc, pulses, consec;
        int acc_cyc [3];
        logic prev_w, go;
        acc = 0; pulses = 0; consec = 0; prev_w = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 6'd0; req_wdata = 16'h1000;
        #1;
        for (int c = 0; c < 8; c++) begin
            go = 1'b0;
            if (req_valid && req_ready) begin
                acc_cyc[acc] = c;
                acc++;
                go = 1'b1;
            end
            tick;
            if (go) begin
                if (acc == 3) req_valid = 1'b0;
                else begin
                    req_addr  = acc[5:0];
                    req_wdata = 16'h1000 + 16'(acc);
                end
            end
            if (ram_w && prev_w) consec++;
            prev_w = ram_w;
            if (rsp_valid) pulses++;
        end
        n_cmp++;
        if (acc != 3 || acc_cyc[0] != 0 || acc_cyc[1] != 2 || acc_cyc[2] != 4) begin
            n_err++;
            $display("FAIL b2b_accept: count=%0d at %0d,%0d,%0d required 3 at 0,2,4", acc, acc_cyc[0], acc_cyc[1], acc_cyc[2]);
        end
        n_cmp++;
        if (pulses != 3 || consec != 0) begin
            n_err++;
            $display("FAIL b2b_rsp: pulses=%0d consecutive_w=%0d required 3 0", pulses, consec);
        end
        n_cmp++;
        if (mem[0] !== 16'h1000 || mem[1] !== 16'h1001 || mem[2] !== 16'h1002) begin
            n_err++;
            $display("FAIL b2b_data: %h %h %h required 1000 1001 1002", mem[0], mem[1], mem[2]);
        end
    endtask

    task automatic test_clear;
        int busy, done_cnt, done_at;
        logic addr_ok, v;
        logic [15:0] d;
        busy = 0; done_cnt = 0; done_at = -1; addr_ok = 1'b1;
        do_write(6'd63, 16'hFFFF);
        clr_start = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL clr_ready_gate: got %b required 0", req_ready);
        end
        tick;
        clr_start = 1'b0;
        for (int c = 0; c < 80; c++) begin
            if (clr_busy) begin
                if (ram_addr !== busy[5:0] || ram_din !== 16'h0 || ram_w !== 1'b1 || ram_e !== 1'b1 || ram_r !== 1'b0)
                    addr_ok = 1'b0;
                busy++;
            end
            if (clr_done) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            clr_start = (c == 10);
            tick;
        end
        clr_start = 1'b0;
        n_cmp++;
        if (busy != 64 || done_cnt != 1 || done_at != 64) begin
            n_err++;
            $display("FAIL clr_timing: busy=%0d done=%0d done_at=%0d required 64 1 64", busy, done_cnt, done_at);
        end
        n_cmp++;
        if (!addr_ok) begin
            n_err++;
            $display("FAIL clr_sweep: strobes/address sequence wrong, required addr 0..63 w=1 din=0");
        end
        do_read(6'd63, d, v);
        n_cmp++;
        if (v !== 1'b1 || d !== 16'h0000) begin
            n_err++;
            $display("FAIL clr_read63: rv=%b rdata=%h required 1 0000", v, d);
        end
    endtask

    task automatic test_clr_priority;
        int busy, stall_bad;
        logic v;
        logic [15:0] d;
        busy = 0; stall_bad = 0;
        clr_start = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 6'd7; req_wdata = 16'h1234;
        #1;
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL prio_ready: got %b required 0", req_ready);
        end
        tick;
        clr_start = 1'b0;
        for (int c = 0; c < 80 && !clr_done; c++) begin
            if (clr_busy) busy++;
            if (req_ready || rsp_valid) stall_bad++;
            tick;
        end
        n_cmp++;
        if (busy != 64 || stall_bad != 0 || clr_done !== 1'b1 || req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL prio_clr: busy=%0d stall_bad=%0d done=%b rdy=%b required 64 0 1 1", busy, stall_bad, clr_done, req_ready);
        end
        tick;
        req_valid = 1'b0;
        n_cmp++;
        if (ram_w !== 1'b1 || ram_addr !== 6'd7 || ram_din !== 16'h1234 || clr_done !== 1'b0) begin
            n_err++;
            $display("FAIL prio_served: w=%b addr=%0d din=%h done=%b required 1 7 1234 0", ram_w, ram_addr, ram_din, clr_done);
        end
        tick;
        tick;
        do_read(6'd7, d, v);
        n_cmp++;
        if (v !== 1'b1 || d !== 16'h1234) begin
            n_err++;
            $display("FAIL prio_read: rv=%b rdata=%h required 1 1234", v, d);
        end
    endtask

    task automatic test_reset_mid_clear;
        int done_seen;
        logic v;
        logic [15:0] d;
        done_seen = 0;
        clr_start = 1'b1;
        tick;
        clr_start = 1'b0;
        for (int c = 0; c < 20; c++) tick;
        n_cmp++;
        if (clr_busy !== 1'b1 || ram_addr !== 6'd20) begin
            n_err++;
            $display("FAIL mid_clr_pos: busy=%b addr=%0d required 1 20", clr_busy, ram_addr);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({req_ready, ram_e, ram_w, ram_r, rsp_valid, clr_busy, clr_done} !== 7'b0 || rsp_rdata !== 16'h0
            || ram_addr !== 6'd0 || ram_din !== 16'h0) begin
            n_err++;
            $display("FAIL async_reset: rdy=%b e=%b w=%b r=%b rv=%b busy=%b done=%b rdata=%h addr=%0d required all 0",
                     req_ready, ram_e, ram_w, ram_r, rsp_valid, clr_busy, clr_done, rsp_rdata, ram_addr);
        end
        for (int c = 0; c < 2; c++) begin
            tick;
            if (clr_done) done_seen++;
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick;
            if (clr_done || clr_busy) done_seen++;
        end
        n_cmp++;
        if (done_seen != 0) begin
            n_err++;
            $display("FAIL reset_no_done: done/busy seen %0d times required 0", done_seen);
        end
        do_write(6'd9, 16'h5A5A);
        do_read(6'd9, d, v);
        n_cmp++;
        if (v !== 1'b1 || d !== 16'h5A5A) begin
            n_err++;
            $display("FAIL post_reset_read: rv=%b rdata=%h required 1 5a5a", v, d);
        end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_back_to_back;
        test_clear;
        test_clr_priority;
        test_reset_mid_clear;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
